// File: rtl/uart_rx_axis_if.sv
// Stream handshake bundle carrying received UART words downstream.
interface uart_rx_axis_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1-style, DATA_WIDTH data bits, no parity) with a one-word stream output.
// Bit period is prescale*8 clk cycles; each bit is sampled near its centre.
module uart_rx_axis #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    uart_rx_axis_if.master        m_axis,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error
);

    localparam int unsigned CntW = 19;
    localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state;
    logic                  rxd_meta;
    logic                  rxd_sync;
    logic [15:0]           p_now;
    logic [15:0]           p_q;
    logic [CntW-1:0]       cnt;
    logic [CntW-1:0]       half_reload;
    logic [CntW-1:0]       bit_reload;
    logic [IdxW-1:0]       bit_idx;
    logic [DATA_WIDTH-1:0] shreg;

    // A prescale of zero would stall the counter, so treat it as one.
    assign p_now       = (prescale == 16'd0) ? 16'd1 : prescale;
    assign half_reload = {1'b0, p_now, 2'b00} - CntW'(1);
    // Full-bit reload uses the latched period so mid-frame prescale changes are ignored.
    assign bit_reload  = {p_q, 3'b000} - CntW'(1);

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Receive FSM, shift register and registered stream/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            cnt           <= '0;
            p_q           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            busy          <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            if (m_axis.tvalid && m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (!rxd_sync) begin
                        p_q   <= p_now;
                        cnt   <= half_reload;
                        busy  <= 1'b1;
                        state <= StStart;
                    end
                end
                StStart: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CntW'(1);
                    end else if (!rxd_sync) begin
                        cnt     <= bit_reload;
                        bit_idx <= '0;
                        state   <= StData;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as a glitch.
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                StData: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CntW'(1);
                    end else begin
                        // LSB-first: shift in at the top so the first bit ends at bit 0.
                        shreg <= DATA_WIDTH'({rxd_sync, shreg} >> 1);
                        cnt   <= bit_reload;
                        if (bit_idx == IdxW'(DATA_WIDTH - 1)) begin
                            state <= StStop;
                        end else begin
                            bit_idx <= bit_idx + IdxW'(1);
                        end
                    end
                end
                StStop: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CntW'(1);
                    end else begin
                        busy  <= 1'b0;
                        state <= StIdle;
                        if (rxd_sync) begin
                            m_axis.tdata  <= shreg;
                            m_axis.tvalid <= 1'b1;
                            // A same-cycle handshake consumes the old word, so no loss.
                            if (m_axis.tvalid && !m_axis.tready) begin
                                overrun_error <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
